// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite slave bus bundle for the register bank.
// The slave modport is used by axi_lite_regbank, the master modport by the bus driver.
interface axi_lite_regbank_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank: ID, W1C IRQ status/enable, RW and RO arrays.
// Define AXI_LITE_REGBANK_WSTROBE_EN to add the per-register rw_wr_pulse output.
module axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_RW    = 8,
  parameter int NUM_RO    = 4,
  parameter int IRQ_WIDTH = 8,
  parameter logic [NUM_RW*32-1:0] RW_RESET_VAL = '0,
  parameter logic [31:0] VERSION = 32'h20250100
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  axi_lite_regbank_if.slave    s_axi,
  output logic [NUM_RW*32-1:0] rw_regs,
  input  logic [NUM_RO*32-1:0] ro_regs,
  input  logic [IRQ_WIDTH-1:0] irq_event,
  output logic                 irq
`ifdef AXI_LITE_REGBANK_WSTROBE_EN
  ,
  output logic [NUM_RW-1:0]    rw_wr_pulse
`endif
);

  localparam int WA  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int RWB = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int ROB = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] RW_LO = 32'd4;
  localparam logic [31:0] RO_LO = 32'(4 + NUM_RW);
  localparam logic [31:0] RO_HI = 32'(4 + NUM_RW + NUM_RO);

  typedef enum logic [2:0] {
    K_ID, K_STAT, K_EN, K_RSV, K_RW, K_RO, K_BAD
  } kind_t;

  function automatic kind_t kind_of(input logic [WA-1:0] w);
    logic [31:0] wi;
    kind_t k;
    wi = 32'(w);
    k  = K_BAD;
    unique case (1'b1)
      (wi == 32'd0): k = K_ID;
      (wi == 32'd1): k = K_STAT;
      (wi == 32'd2): k = K_EN;
      (wi == 32'd3): k = K_RSV;
      (wi >= RW_LO && wi < RO_LO): k = K_RW;
      (wi >= RO_LO && wi < RO_HI): k = K_RO;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

  logic [31:0]          rw_q [NUM_RW];
  logic [31:0]          ro_w [NUM_RO];
  logic [IRQ_WIDTH-1:0] stat_q;
  logic [IRQ_WIDTH-1:0] en_q;

  logic          awready_q, wready_q, bvalid_q;
  logic          arready_q, rvalid_q;
  logic          aw_held, w_held;
  logic [WA-1:0] aw_word;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic          aw_held_nxt, w_held_nxt, rvalid_nxt;
  kind_t         wr_kind, rd_kind;
  logic [31:0]   wr_wi, rd_wi;
  logic [RWB-1:0] wr_rw_i, rd_rw_i;
  logic [ROB-1:0] rd_ro_i;
  logic [31:0]   wmask, wbits;
  logic [31:0]   rd_data;
  logic [1:0]    rd_resp;
  logic          unused_ok;

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    assign rw_regs[32*i +: 32] = rw_q[i];
  end
  for (genvar j = 0; j < NUM_RO; j++) begin : g_ro
    assign ro_w[j] = ro_regs[32*j +: 32];
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs   = s_axi.S_AXI_WVALID & wready_q;
  assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
  assign commit = aw_held & w_held & ~bvalid_q;

  assign aw_held_nxt = commit ? 1'b0 : (aw_held | aw_hs);
  assign w_held_nxt  = commit ? 1'b0 : (w_held | w_hs);
  assign rvalid_nxt  = ar_hs | (rvalid_q & ~s_axi.S_AXI_RREADY);

  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                       wbits, wr_wi, rd_wi};

  // Decode the held write address and build the byte-lane mask.
  always_comb begin
    wr_kind = kind_of(aw_word);
    wr_wi   = 32'(aw_word);
    wr_rw_i = RWB'(wr_wi - RW_LO);
    wmask   = {{8{w_strb[3]}}, {8{w_strb[2]}},
               {8{w_strb[1]}}, {8{w_strb[0]}}};
    wbits   = w_data & wmask;
  end

  // Decode the incoming read address into data and response.
  always_comb begin
    rd_kind = kind_of(s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    rd_wi   = 32'(s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    rd_rw_i = RWB'(rd_wi - RW_LO);
    rd_ro_i = ROB'(rd_wi - RO_LO);
    rd_data = '0;
    rd_resp = OKAY;
    unique case (rd_kind)
      K_ID:   rd_data = VERSION;
      K_STAT: rd_data = 32'(stat_q);
      K_EN:   rd_data = 32'(en_q);
      K_RSV:  rd_data = '0;
      K_RW:   rd_data = rw_q[rd_rw_i];
      K_RO:   rd_data = ro_w[rd_ro_i];
      K_BAD:  rd_resp = SLVERR;
      default: rd_resp = SLVERR;
    endcase
  end

  // Write channel: hold AW and W independently, commit once both are held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      awready_q <= ~aw_held_nxt;
      wready_q  <= ~w_held_nxt;
      if (aw_hs) aw_word <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_kind == K_BAD) ? SLVERR : OKAY;
      end else if (s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: capture data on the AR handshake, hold until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      rvalid_q  <= rvalid_nxt;
      arready_q <= ~rvalid_nxt;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  // RW register array with per-lane strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_RW; i++)
        rw_q[i] <= RW_RESET_VAL[32*i +: 32];
    end else if (commit && wr_kind == K_RW) begin
      rw_q[wr_rw_i] <= (rw_q[wr_rw_i] & ~wmask) | wbits;
    end
  end

  // IRQ status (event set beats W1C), enable, and registered level.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stat_q <= '0;
      en_q   <= '0;
      irq    <= 1'b0;
    end else begin
      if (commit && wr_kind == K_STAT)
        stat_q <= (stat_q & ~wbits[IRQ_WIDTH-1:0]) | irq_event;
      else
        stat_q <= stat_q | irq_event;
      if (commit && wr_kind == K_EN)
        en_q <= (en_q & ~wmask[IRQ_WIDTH-1:0]) | wbits[IRQ_WIDTH-1:0];
      irq <= |(stat_q & en_q);
    end
  end

`ifdef AXI_LITE_REGBANK_WSTROBE_EN
  // One-cycle pulse per RW register, aligned with BVALID rising.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rw_wr_pulse <= '0;
    end else begin
      rw_wr_pulse <= '0;
      if (commit && wr_kind == K_RW)
        rw_wr_pulse[wr_rw_i] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: handshakes, strobes, errors, IRQ, reset.
// Optional rw_wr_pulse checks follow AXI_LITE_REGBANK_WSTROBE_EN.
module tb_axi_lite_regbank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ro_regs;
  logic [7:0]   irq_event = '0;
  logic         irq;
  logic [255:0] rw_regs;
  int           nvec = 0;
  int           nerr = 0;
  logic [31:0]  d;
  logic [1:0]   r;
  int           bcnt;

  axi_lite_regbank_if #(.AW(8), .DW(32)) bus ();

`ifdef AXI_LITE_REGBANK_WSTROBE_EN
  logic [7:0] rw_wr_pulse;
  int         pulse2 = 0;
  always @(posedge clk) if (rw_wr_pulse[2]) pulse2++;
`endif

  axi_lite_regbank dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .rw_regs       (rw_regs),
    .ro_regs       (ro_regs),
    .irq_event     (irq_event),
    .irq           (irq)
`ifdef AXI_LITE_REGBANK_WSTROBE_EN
    ,
    .rw_wr_pulse   (rw_wr_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dat,
                    input logic [3:0] s, output logic [1:0] resp);
    logic ag, wg;
    int n;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = dat;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    resp = 2'b11;
    n = 0;
    while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 16) begin
      ag = bus.S_AXI_AWREADY;
      wg = bus.S_AXI_WREADY;
      step();
      if (ag) bus.S_AXI_AWVALID = 1'b0;
      if (wg) bus.S_AXI_WVALID = 1'b0;
      n++;
    end
    while (!bus.S_AXI_BVALID && n < 16) begin
      step();
      n++;
    end
    chk("wr_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    if (bus.S_AXI_BVALID) begin
      resp = bus.S_AXI_BRESP;
      step();
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input bit rnd,
                    output logic [31:0] dat, output logic [1:0] resp);
    logic g;
    logic [31:0] first;
    bit seen, stable, done;
    int n;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (bus.S_AXI_ARVALID && n < 16) begin
      g = bus.S_AXI_ARREADY;
      step();
      if (g) bus.S_AXI_ARVALID = 1'b0;
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    first = '0;
    resp = 2'b11;
    seen = 0;
    stable = 1;
    done = 0;
    while (!done && n < 64) begin
      bus.S_AXI_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.S_AXI_RVALID) begin
        if (!seen) begin
          first = bus.S_AXI_RDATA;
          resp = bus.S_AXI_RRESP;
          seen = 1;
        end else if (bus.S_AXI_RDATA !== first) begin
          stable = 0;
        end
        if (bus.S_AXI_RREADY) done = 1;
      end
      step();
      n++;
    end
    bus.S_AXI_RREADY = 1'b0;
    dat = first;
    chk("rd_done", 32'(done), 32'd1);
    if (rnd) chk("rdata_stable", 32'(stable), 32'd1);
  endtask

  initial begin
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    ro_regs = {32'hDDDD4444, 32'hCCCC3333, 32'hBBBB2222, 32'hAAAA1111};

    // Reset state
    step();
    step();
    chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rw0", rw_regs[31:0], 32'd0);
    rst_n = 1'b1;
    step();
    chk("awready_up", 32'(bus.S_AXI_AWREADY), 32'd1);
    rd(8'h00, 0, d, r);
    chk("id_data", d, 32'h20250100);
    chk("id_resp", 32'(r), 32'd0);
    rd(8'h10, 0, d, r);
    chk("rw0_reset", d, 32'd0);

    // W two cycles before AW, sparse strobes
    bus.S_AXI_WDATA  = 32'hA5A55A5A;
    bus.S_AXI_WSTRB  = 4'b0101;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_WVALID = 1'b0;
    chk("wready_held", 32'(bus.S_AXI_WREADY), 32'd0);
    step();
    step();
    chk("no_early_b", 32'(bus.S_AXI_BVALID), 32'd0);
    bus.S_AXI_AWADDR  = 8'h14;
    bus.S_AXI_AWVALID = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    bcnt = 0;
    r = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (bus.S_AXI_BVALID) begin
        bcnt++;
        r = bus.S_AXI_BRESP;
      end
      step();
    end
    bus.S_AXI_BREADY = 1'b0;
    chk("wfirst_bcount", 32'(bcnt), 32'd1);
    chk("wfirst_bresp", 32'(r), 32'd0);
    rd(8'h14, 0, d, r);
    chk("wfirst_rdback", d, 32'h00A5005A);

    // AW and W together, BREADY low for 3 cycles
    bus.S_AXI_AWADDR  = 8'h18;
    bus.S_AXI_WDATA   = 32'h12345678;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("b_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      step();
    end
    chk("b_hold_resp", 32'(bus.S_AXI_BRESP), 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_BREADY = 1'b0;
    chk("b_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("rw2_port", rw_regs[95:64], 32'h12345678);
    rd(8'h18, 0, d, r);
    chk("rw2_rdback", d, 32'h12345678);

    // Error and ignored writes
    wr(8'hFC, 32'hFFFFFFFF, 4'hF, r);
    chk("unmapped_bresp", 32'(r), 32'd2);
    chk("unm_rw0", rw_regs[31:0], 32'd0);
    chk("unm_rw1", rw_regs[63:32], 32'h00A5005A);
    chk("unm_rw2", rw_regs[95:64], 32'h12345678);
    chk("unm_rest", 32'(|rw_regs[255:96]), 32'd0);
    rd(8'hFC, 0, d, r);
    chk("unmapped_rdata", d, 32'd0);
    chk("unmapped_rresp", 32'(r), 32'd2);
    wr(8'h30, 32'hFFFFFFFF, 4'hF, r);
    chk("ro_wr_resp", 32'(r), 32'd0);
    rd(8'h30, 0, d, r);
    chk("ro_wr_ignored", d, 32'hAAAA1111);
    wr(8'h00, 32'h0, 4'hF, r);
    chk("id_wr_resp", 32'(r), 32'd0);
    rd(8'h00, 0, d, r);
    chk("id_unchanged", d, 32'h20250100);

    // IRQ set, registered level
    wr(8'h08, 32'h3, 4'hF, r);
    chk("en_wr_resp", 32'(r), 32'd0);
    irq_event = 8'h01;
    step();
    irq_event = 8'h00;
    chk("irq_lag", 32'(irq), 32'd0);
    step();
    chk("irq_set", 32'(irq), 32'd1);
    rd(8'h04, 0, d, r);
    chk("stat_set", d, 32'h1);

    // W1C colliding with a set event: set wins
    bus.S_AXI_AWADDR  = 8'h04;
    bus.S_AXI_WDATA   = 32'h1;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    irq_event = 8'h01;
    step();
    irq_event = 8'h00;
    chk("w1c_coll_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    step();
    bus.S_AXI_BREADY = 1'b0;
    rd(8'h04, 0, d, r);
    chk("stat_set_wins", d, 32'h1);
    chk("irq_still", 32'(irq), 32'd1);

    // W1C alone clears
    wr(8'h04, 32'h1, 4'hF, r);
    rd(8'h04, 0, d, r);
    chk("stat_clr", d, 32'h0);
    chk("irq_clr", 32'(irq), 32'd0);

    // Enable width and lane strobes
    wr(8'h08, 32'hFFFFFFFF, 4'hF, r);
    rd(8'h08, 0, d, r);
    chk("en_width", d, 32'h000000FF);
    wr(8'h08, 32'h0, 4'b0010, r);
    rd(8'h08, 0, d, r);
    chk("en_strb", d, 32'h000000FF);

    // RO back-to-back with random RREADY
    for (int j = 0; j < 4; j++) begin
      rd(8'(8'h30 + 4 * j), 1, d, r);
      chk("ro_data", d, ro_regs[32*j +: 32]);
      chk("ro_resp", 32'(r), 32'd0);
    end

`ifdef AXI_LITE_REGBANK_WSTROBE_EN
    chk("pulse2_once", 32'(pulse2), 32'd1);
`endif

    // Async reset with BVALID, RVALID and irq high
    irq_event = 8'h02;
    step();
    irq_event = 8'h00;
    bus.S_AXI_AWADDR  = 8'h14;
    bus.S_AXI_WDATA   = 32'hFFFFFFFF;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    step();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    step();
    bus.S_AXI_ARADDR  = 8'h10;
    bus.S_AXI_ARVALID = 1'b1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    chk("pre_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("pre_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    chk("pre_rst_rw1", rw_regs[63:32], 32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("arst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_rw1", rw_regs[63:32], 32'd0);
    chk("arst_rw2", rw_regs[95:64], 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rd(8'h04, 0, d, r);
    chk("post_stat", d, 32'd0);
    rd(8'h08, 0, d, r);
    chk("post_en", d, 32'd0);
    rd(8'h18, 0, d, r);
    chk("post_rw2", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
